// File: rtl/player_pkg.sv
// Shared types and constants for the player sprite motion controller.
package player_pkg;

  typedef enum logic [1:0] {
    GROUNDED = 2'd0,
    RISING   = 2'd1,
    FALLING  = 2'd2
  } state_t;

  localparam int unsigned KEY_W  = 16;
  localparam int unsigned VEL_W  = 8;
  localparam int unsigned POS_W  = 10;
  localparam int unsigned CALC_W = 12;

  localparam logic [KEY_W-1:0] KEY_LEFT  = 16'h0004;
  localparam logic [KEY_W-1:0] KEY_RIGHT = 16'h0007;
  localparam logic [KEY_W-1:0] KEY_JUMP  = 16'h001A;
  localparam logic [KEY_W-1:0] KEY_NONE  = 16'h0000;

endpackage

// File: rtl/key_edge_detect.sv
// Rising-edge detector for the jump keycode: high for the first frame the jump key is seen.
module key_edge_detect
  import player_pkg::*;
(
  input  logic             frame_clk,
  input  logic             Reset,
  input  logic [KEY_W-1:0] i_key,
  output logic             o_jump_edge_c
);

  logic w_is_jump;
  logic r_jump_prev;

  assign w_is_jump = (i_key == KEY_JUMP);

  // Remember whether the previous frame's key was jump.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      r_jump_prev <= 1'b0;
    end else begin
      r_jump_prev <= w_is_jump;
    end
  end

  assign o_jump_edge_c = w_is_jump & ~r_jump_prev;

endmodule

// File: rtl/player_motion.sv
// Per-frame motion controller for a square player sprite: clamped horizontal
// stepping plus a grounded/rising/falling jump FSM with signed vertical velocity.
// Optional macro PLAYER_DOUBLE_JUMP_EN allows one extra jump per airborne period.
module player_motion
  import player_pkg::*;
#(
  parameter int X_START  = 320,
  parameter int Y_START  = 475,
  parameter int X_MIN    = 0,
  parameter int X_MAX    = 639,
  parameter int Y_MIN    = 0,
  parameter int FLOOR_Y  = 479,
  parameter int SIZE     = 4,
  parameter int X_STEP   = 2,
  parameter int JUMP_VEL = 8,
  parameter int GRAVITY  = 1,
  parameter int MAX_FALL = 8
) (
  input  logic             frame_clk,
  input  logic             Reset,
  input  logic [KEY_W-1:0] key,
  output logic [POS_W-1:0] PosX,
  output logic [POS_W-1:0] PosY,
  output logic [POS_W-1:0] Size,
  output logic [VEL_W-1:0] VelY,
  output logic [1:0]       state,
  output logic             on_ground
);

  localparam logic signed [CALC_W-1:0] C_X_MIN    = CALC_W'(X_MIN);
  localparam logic signed [CALC_W-1:0] C_X_MAX    = CALC_W'(X_MAX);
  localparam logic signed [CALC_W-1:0] C_Y_MIN    = CALC_W'(Y_MIN);
  localparam logic signed [CALC_W-1:0] C_FLOOR    = CALC_W'(FLOOR_Y);
  localparam logic signed [CALC_W-1:0] C_SIZE     = CALC_W'(SIZE);
  localparam logic signed [CALC_W-1:0] C_X_STEP   = CALC_W'(X_STEP);
  localparam logic signed [CALC_W-1:0] C_JUMP_VEL = CALC_W'(JUMP_VEL);
  localparam logic signed [CALC_W-1:0] C_GRAVITY  = CALC_W'(GRAVITY);
  localparam logic signed [CALC_W-1:0] C_MAX_FALL = CALC_W'(MAX_FALL);

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic        [POS_W-1:0]   r_pos_x;
  logic        [POS_W-1:0]   r_pos_y;
  logic signed [VEL_W-1:0]   r_vel_y;
  logic                      r_on_ground;

  logic        [POS_W-1:0]   w_pos_x_nxt;
  logic        [POS_W-1:0]   w_pos_y_nxt;
  logic signed [VEL_W-1:0]   w_vel_nxt;
  logic signed [CALC_W-1:0]  w_vx;
  logic signed [CALC_W-1:0]  w_nx;
  logic signed [CALC_W-1:0]  w_vy;
  logic signed [CALC_W-1:0]  w_ny;
  logic signed [CALC_W-1:0]  w_vy_grav;
  logic                      w_jump_edge;

`ifdef PLAYER_DOUBLE_JUMP_EN
  logic r_air_jump_used;
  logic w_air_jump_nxt;
`endif

  key_edge_detect u_key_edge (
    .frame_clk     (frame_clk),
    .Reset         (Reset),
    .i_key         (key),
    .o_jump_edge_c (w_jump_edge)
  );

  // Horizontal step with clamping to the playfield; no stored momentum.
  always_comb begin
    w_vx = '0;
    if (key == KEY_LEFT) begin
      w_vx = -C_X_STEP;
    end else if (key == KEY_RIGHT) begin
      w_vx = C_X_STEP;
    end
    w_nx        = $signed({2'b00, r_pos_x}) + w_vx;
    w_pos_x_nxt = POS_W'(w_nx);
    if (w_nx + C_SIZE > C_X_MAX) begin
      w_pos_x_nxt = POS_W'(C_X_MAX - C_SIZE);
    end else if (w_nx < C_X_MIN + C_SIZE) begin
      w_pos_x_nxt = POS_W'(C_X_MIN + C_SIZE);
    end
  end

  // Airborne kinematics: candidate position and gravity-limited velocity.
  always_comb begin
    w_vy      = $signed({{(CALC_W-VEL_W){r_vel_y[VEL_W-1]}}, r_vel_y});
    w_ny      = $signed({2'b00, r_pos_y}) + w_vy;
    w_vy_grav = w_vy + C_GRAVITY;
    if (w_vy_grav > C_MAX_FALL) begin
      w_vy_grav = C_MAX_FALL;
    end
  end

  // Jump FSM next-state and vertical datapath; landing beats ceiling beats gravity.
  always_comb begin
    w_state_nxt = r_state;
    w_pos_y_nxt = r_pos_y;
    w_vel_nxt   = r_vel_y;
`ifdef PLAYER_DOUBLE_JUMP_EN
    w_air_jump_nxt = r_air_jump_used;
`endif
    case (r_state)
      GROUNDED: begin
        w_vel_nxt = '0;
        if (w_jump_edge) begin
          w_vel_nxt   = VEL_W'(-C_JUMP_VEL);
          w_state_nxt = RISING;
        end
      end
      RISING, FALLING: begin
        if (w_ny + C_SIZE >= C_FLOOR) begin
          w_pos_y_nxt = POS_W'(C_FLOOR - C_SIZE);
          w_vel_nxt   = '0;
          w_state_nxt = GROUNDED;
`ifdef PLAYER_DOUBLE_JUMP_EN
          w_air_jump_nxt = 1'b0;
`endif
        end else if (w_ny < C_Y_MIN + C_SIZE) begin
          w_pos_y_nxt = POS_W'(C_Y_MIN + C_SIZE);
          w_vel_nxt   = '0;
          w_state_nxt = FALLING;
`ifdef PLAYER_DOUBLE_JUMP_EN
        end else if (w_jump_edge && !r_air_jump_used) begin
          w_vel_nxt      = VEL_W'(-C_JUMP_VEL);
          w_state_nxt    = RISING;
          w_air_jump_nxt = 1'b1;
`endif
        end else begin
          w_pos_y_nxt = POS_W'(w_ny);
          w_vel_nxt   = VEL_W'(w_vy_grav);
          w_state_nxt = w_vy_grav[CALC_W-1] ? RISING : FALLING;
        end
      end
      default: begin
        w_state_nxt = FALLING;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      r_state <= GROUNDED;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Position, velocity and status registers.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      r_pos_x     <= POS_W'(X_START);
      r_pos_y     <= POS_W'(Y_START);
      r_vel_y     <= '0;
      r_on_ground <= 1'b1;
    end else begin
      r_pos_x     <= w_pos_x_nxt;
      r_pos_y     <= w_pos_y_nxt;
      r_vel_y     <= w_vel_nxt;
      r_on_ground <= (w_state_nxt == GROUNDED);
    end
  end

`ifdef PLAYER_DOUBLE_JUMP_EN
  // One extra jump per airborne period; cleared on landing.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      r_air_jump_used <= 1'b0;
    end else begin
      r_air_jump_used <= w_air_jump_nxt;
    end
  end
`endif

  assign PosX      = r_pos_x;
  assign PosY      = r_pos_y;
  assign Size      = POS_W'(SIZE);
  assign VelY      = r_vel_y;
  assign state     = r_state;
  assign on_ground = r_on_ground;

endmodule
